// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus scheduler.
// Holds the state encoding, requester indices and idle bus levels.
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR_SETUP,
        ST_ADDR_STROBE,
        ST_ADDR_HOLD,
        ST_GAP,
        ST_DATA_SETUP,
        ST_DATA_STROBE,
        ST_DATA_HOLD,
        ST_RECOVER
    } state_e;

    localparam int REQ_INI = 0;
    localparam int REQ_ESC = 1;
    localparam int REQ_LEC = 2;

    localparam logic CS_N_IDLE = 1'b1;
    localparam logic RD_N_IDLE = 1'b1;
    localparam logic WR_N_IDLE = 1'b1;
    localparam logic A_D_IDLE  = 1'b1;

    // Fixed walk through the bus sequence; RECOVER hands back to IDLE.
    function automatic state_e next_state(input state_e s);
        case (s)
            ST_ADDR_SETUP:  next_state = ST_ADDR_STROBE;
            ST_ADDR_STROBE: next_state = ST_ADDR_HOLD;
            ST_ADDR_HOLD:   next_state = ST_GAP;
            ST_GAP:         next_state = ST_DATA_SETUP;
            ST_DATA_SETUP:  next_state = ST_DATA_STROBE;
            ST_DATA_STROBE: next_state = ST_DATA_HOLD;
            ST_DATA_HOLD:   next_state = ST_RECOVER;
            default:        next_state = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Down-counter timing each bus state; reloaded on every state transition,
// last_o marks the final cycle of the current state.
module rtc_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] dur_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = dur_i - W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_sched.sv
// Arbitrates init/write/read requesters and sequences the RTC multiplexed
// address/data bus: address phase, gap, data phase, recovery.
module rtc_bus_sched
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 6,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 10,
    parameter int T_REC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_i,
    input  logic [2:0]  rnw_i,
    input  logic [23:0] addr_i,
    input  logic [23:0] wdata_i,
    output logic [2:0]  gnt_o,
    output logic [2:0]  done_o,
    output logic [7:0]  rdata_o,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic        cs_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic        a_d
);

    localparam int M_SP  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int M_HG  = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int M_SPH = (M_SP > M_HG) ? M_SP : M_HG;
    localparam int T_MAX = (M_SPH > T_REC) ? M_SPH : T_REC;
    localparam int TW    = $clog2(T_MAX) + 1;

    logic [7:0] addr_a  [3];
    logic [7:0] wdata_a [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
        assign addr_a[gi]  = addr_i[8*gi +: 8];
        assign wdata_a[gi] = wdata_i[8*gi +: 8];
    end

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        rnw_q, rnw_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        lec_last_q, lec_last_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [2:0]  done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        a_d_q, a_d_d;
    logic        ad_oe_q, ad_oe_d;
    logic [7:0]  ad_out_q, ad_out_d;

    logic          win_valid;
    logic [1:0]    win_idx;
    logic          load;
    logic [TW-1:0] load_dur;
    logic          timer_last;

    function automatic logic [TW-1:0] dur_of(input state_e s);
        case (s)
            ST_ADDR_SETUP, ST_DATA_SETUP:   dur_of = TW'(T_SETUP);
            ST_ADDR_STROBE, ST_DATA_STROBE: dur_of = TW'(T_PULSE);
            ST_ADDR_HOLD, ST_DATA_HOLD:     dur_of = TW'(T_HOLD);
            ST_GAP:                         dur_of = TW'(T_GAP);
            ST_RECOVER:                     dur_of = TW'(T_REC);
            default:                        dur_of = TW'(1);
        endcase
    endfunction

    // Init always wins; between write and read, the one not served last wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'(REQ_INI);
        if (req_i[REQ_INI]) begin
            win_valid = 1'b1;
            win_idx   = 2'(REQ_INI);
        end else if (req_i[REQ_ESC] && req_i[REQ_LEC]) begin
            win_valid = 1'b1;
            win_idx   = lec_last_q ? 2'(REQ_ESC) : 2'(REQ_LEC);
        end else if (req_i[REQ_ESC]) begin
            win_valid = 1'b1;
            win_idx   = 2'(REQ_ESC);
        end else if (req_i[REQ_LEC]) begin
            win_valid = 1'b1;
            win_idx   = 2'(REQ_LEC);
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lec_last_d = lec_last_q;
        gnt_d      = '0;
        done_d     = '0;
        rdata_d    = rdata_q;
        load       = 1'b0;

        if (state_q == ST_IDLE) begin
            if (win_valid) begin
                state_d = ST_ADDR_SETUP;
                load    = 1'b1;
                idx_d   = win_idx;
                gnt_d   = 3'b001 << win_idx;
                case (win_idx)
                    2'd1: begin
                        rnw_d      = rnw_i[1];
                        addr_d     = addr_a[1];
                        wdata_d    = wdata_a[1];
                        lec_last_d = 1'b0;
                    end
                    2'd2: begin
                        rnw_d      = rnw_i[2];
                        addr_d     = addr_a[2];
                        wdata_d    = wdata_a[2];
                        lec_last_d = 1'b1;
                    end
                    default: begin
                        rnw_d   = rnw_i[0];
                        addr_d  = addr_a[0];
                        wdata_d = wdata_a[0];
                    end
                endcase
            end
        end else if (timer_last) begin
            state_d = next_state(state_q);
            load    = (state_d != ST_IDLE);
            if (state_q == ST_DATA_STROBE && rnw_q) begin
                rdata_d = ad_in;
            end
            if (state_q == ST_RECOVER) begin
                done_d = 3'b001 << idx_q;
            end
        end
    end

    assign load_dur = dur_of(state_d);

    // Bus levels are derived from the upcoming state so the pins are registered.
    always_comb begin
        cs_n_d   = CS_N_IDLE;
        rd_n_d   = RD_N_IDLE;
        wr_n_d   = WR_N_IDLE;
        a_d_d    = A_D_IDLE;
        ad_oe_d  = 1'b0;
        ad_out_d = '0;
        case (state_d)
            ST_ADDR_SETUP, ST_ADDR_STROBE, ST_ADDR_HOLD: begin
                cs_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
                wr_n_d   = (state_d == ST_ADDR_STROBE) ? 1'b0 : WR_N_IDLE;
            end
            ST_DATA_SETUP, ST_DATA_STROBE, ST_DATA_HOLD: begin
                cs_n_d = 1'b0;
                a_d_d  = 1'b1;
                if (!rnw_d) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end
                if (state_d == ST_DATA_STROBE) begin
                    if (rnw_d) begin
                        rd_n_d = 1'b0;
                    end else begin
                        wr_n_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lec_last_q <= 1'b1;
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            cs_n_q     <= CS_N_IDLE;
            rd_n_q     <= RD_N_IDLE;
            wr_n_q     <= WR_N_IDLE;
            a_d_q      <= A_D_IDLE;
            ad_oe_q    <= 1'b0;
            ad_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lec_last_q <= lec_last_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            a_d_q      <= a_d_d;
            ad_oe_q    <= ad_oe_d;
            ad_out_q   <= ad_out_d;
        end
    end

    rtc_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .dur_i  (load_dur),
        .last_o (timer_last)
    );

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign cs_n    = cs_n_q;
    assign rd_n    = rd_n_q;
    assign wr_n    = wr_n_q;
    assign a_d     = a_d_q;
    assign ad_oe   = ad_oe_q;
    assign ad_out  = ad_out_q;

endmodule

// File: tb/tb_rtc_bus_sched.sv
// Testbench for rtc_bus_sched: default-timing instance plus an all-ones
// timing instance; completions are matched against a queue of expectations.
module tb_rtc_bus_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  req_i, rnw_i;
    logic [23:0] addr_i, wdata_i;
    logic [7:0]  ad_in;
    logic [2:0]  gnt_o, done_o;
    logic [7:0]  rdata_o, ad_out;
    logic        ad_oe, cs_n, rd_n, wr_n, a_d;

    logic [2:0]  s_req, s_rnw;
    logic [23:0] s_addr, s_wdata;
    logic [7:0]  s_ad_in;
    logic [2:0]  s_gnt, s_done;
    logic [7:0]  s_rdata, s_ad_out;
    logic        s_ad_oe, s_cs_n, s_rd_n, s_wr_n, s_a_d;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0] done;
        logic [7:0] rdata;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] exp_rdata = 8'h00;

    rtc_bus_sched dut (
        .clk(clk), .rst(rst), .req_i(req_i), .rnw_i(rnw_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .ad_in(ad_in), .ad_out(ad_out),
        .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d)
    );

    rtc_bus_sched #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1), .T_REC(1)) dut1 (
        .clk(clk), .rst(rst), .req_i(s_req), .rnw_i(s_rnw), .addr_i(s_addr), .wdata_i(s_wdata),
        .gnt_o(s_gnt), .done_o(s_done), .rdata_o(s_rdata), .ad_in(s_ad_in), .ad_out(s_ad_out),
        .ad_oe(s_ad_oe), .cs_n(s_cs_n), .rd_n(s_rd_n), .wr_n(s_wr_n), .a_d(s_a_d)
    );

    // Scoreboard on completions plus bus-safety invariants on both instances.
    always @(negedge clk) begin
        if (rst) begin
            vectors++;
            if (!rd_n && !wr_n) begin miscompares++; $display("FAIL strobe_overlap: rd_n=%b wr_n=%b, required not both low", rd_n, wr_n); end
            vectors++;
            if (ad_oe && !rd_n) begin miscompares++; $display("FAIL drive_during_read: ad_oe=%b rd_n=%b, required not both active", ad_oe, rd_n); end
            vectors++;
            if (!s_rd_n && !s_wr_n) begin miscompares++; $display("FAIL sweep_strobe_overlap: rd_n=%b wr_n=%b, required not both low", s_rd_n, s_wr_n); end
            vectors++;
            if (s_ad_oe && !s_rd_n) begin miscompares++; $display("FAIL sweep_drive_during_read: ad_oe=%b rd_n=%b, required not both active", s_ad_oe, s_rd_n); end
            if (done_o != 3'b000) begin
                $display("txn done=%b rdata=%h", done_o, rdata_o);
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL done_unexpected: got done=%b, required no completion", done_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (done_o !== mon_e.done || rdata_o !== mon_e.rdata) begin
                        miscompares++;
                        $display("FAIL done_scoreboard: got done=%b rdata=%h, required done=%b rdata=%h", done_o, rdata_o, mon_e.done, mon_e.rdata);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({cs_n, rd_n, wr_n, a_d, ad_oe} !== 5'b11110) begin miscompares++; $display("FAIL reset_bus: got cs_n,rd_n,wr_n,a_d,ad_oe=%b, required 11110", {cs_n, rd_n, wr_n, a_d, ad_oe}); end
        vectors++;
        if (ad_out !== 8'h00 || rdata_o !== 8'h00) begin miscompares++; $display("FAIL reset_data: got ad_out=%h rdata=%h, required 00 00", ad_out, rdata_o); end
        vectors++;
        if (gnt_o !== 3'b000 || done_o !== 3'b000) begin miscompares++; $display("FAIL reset_pulses: got gnt=%b done=%b, required 000 000", gnt_o, done_o); end
        vectors++;
        if ({s_cs_n, s_rd_n, s_wr_n, s_a_d, s_ad_oe} !== 5'b11110) begin miscompares++; $display("FAIL reset_sweep_bus: got %b, required 11110", {s_cs_n, s_rd_n, s_wr_n, s_a_d, s_ad_oe}); end
        rst = 1'b1;
        exp_rdata = 8'h00;
        repeat (2) @(negedge clk);
        vectors++;
        if (gnt_o !== 3'b000 || cs_n !== 1'b1) begin miscompares++; $display("FAIL idle_after_reset: got gnt=%b cs_n=%b, required 000 1", gnt_o, cs_n); end
    endtask

    task automatic test_single_write();
        logic wr_exp;
        @(negedge clk);
        req_i = 3'b010; rnw_i[1] = 1'b0; addr_i[15:8] = 8'h21; wdata_i[15:8] = 8'h45;
        exp_q.push_back('{3'b010, exp_rdata});
        @(posedge clk);
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (gnt_o !== 3'b010) begin miscompares++; $display("FAIL write_gnt: got %b, required 010", gnt_o); end
                req_i = 3'b000;
            end
            wr_exp = (c >= 3 && c <= 8) || (c >= 23 && c <= 28);
            vectors++;
            if (wr_n !== !wr_exp) begin miscompares++; $display("FAIL write_wr_n c%0d: got %b, required %b", c, wr_n, !wr_exp); end
            vectors++;
            if (rd_n !== 1'b1) begin miscompares++; $display("FAIL write_rd_n c%0d: got %b, required 1", c, rd_n); end
            if (c >= 3 && c <= 8) begin
                vectors++;
                if (ad_out !== 8'h21 || a_d !== 1'b0 || ad_oe !== 1'b1) begin miscompares++; $display("FAIL write_addr_phase c%0d: got ad_out=%h a_d=%b oe=%b, required 21 0 1", c, ad_out, a_d, ad_oe); end
            end
            if (c >= 23 && c <= 28) begin
                vectors++;
                if (ad_out !== 8'h45 || a_d !== 1'b1 || ad_oe !== 1'b1) begin miscompares++; $display("FAIL write_data_phase c%0d: got ad_out=%h a_d=%b oe=%b, required 45 1 1", c, ad_out, a_d, ad_oe); end
            end
            if (c == 34 || c == 35) begin
                vectors++;
                if (done_o !== ((c == 35) ? 3'b010 : 3'b000)) begin miscompares++; $display("FAIL write_done c%0d: got %b", c, done_o); end
            end
        end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        req_i = 3'b100; rnw_i[2] = 1'b1; addr_i[23:16] = 8'h22; ad_in = 8'h5A;
        exp_rdata = 8'h37;
        exp_q.push_back('{3'b100, exp_rdata});
        @(posedge clk);
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (gnt_o !== 3'b100) begin miscompares++; $display("FAIL read_gnt: got %b, required 100", gnt_o); end
                req_i = 3'b000;
            end
            vectors++;
            if (rd_n !== !(c >= 23 && c <= 28)) begin miscompares++; $display("FAIL read_rd_n c%0d: got %b", c, rd_n); end
            if (c >= 21 && c <= 30) begin
                vectors++;
                if (ad_oe !== 1'b0 || cs_n !== 1'b0) begin miscompares++; $display("FAIL read_data_dir c%0d: got oe=%b cs_n=%b, required 0 0", c, ad_oe, cs_n); end
            end
            if (c >= 1 && c <= 10) begin
                vectors++;
                if (ad_oe !== 1'b1 || ad_out !== 8'h22) begin miscompares++; $display("FAIL read_addr c%0d: got oe=%b ad_out=%h, required 1 22", c, ad_oe, ad_out); end
            end
            if (c == 21) ad_in = 8'h37;
            if (c == 30) ad_in = 8'h5A;
            if (c == 35) begin
                vectors++;
                if (done_o !== 3'b100 || rdata_o !== 8'h37) begin miscompares++; $display("FAIL read_done: got done=%b rdata=%h, required 100 37", done_o, rdata_o); end
            end
        end
    endtask

    task automatic test_priority();
        int         ng = 0;
        int         gcyc [3];
        logic [2:0] gid  [3];
        @(negedge clk);
        req_i = 3'b111; rnw_i = 3'b000; addr_i = 24'h333231; wdata_i = 24'h636261;
        exp_q.push_back('{3'b001, exp_rdata});
        exp_q.push_back('{3'b010, exp_rdata});
        exp_q.push_back('{3'b100, exp_rdata});
        @(posedge clk);
        for (int c = 1; c <= 105; c++) begin
            @(negedge clk);
            if (gnt_o != 3'b000) begin
                if (ng < 3) begin gid[ng] = gnt_o; gcyc[ng] = c; end
                ng++;
                req_i = req_i & ~gnt_o;
            end
        end
        vectors++;
        if (ng != 3) begin miscompares++; $display("FAIL prio_count: got %0d grants, required 3", ng); end
        else begin
            vectors++;
            if (gid[0] !== 3'b001 || gcyc[0] != 1) begin miscompares++; $display("FAIL prio_g0: got %b@%0d, required 001@1", gid[0], gcyc[0]); end
            vectors++;
            if (gid[1] !== 3'b010 || gcyc[1] != 36) begin miscompares++; $display("FAIL prio_g1: got %b@%0d, required 010@36", gid[1], gcyc[1]); end
            vectors++;
            if (gid[2] !== 3'b100 || gcyc[2] != 71) begin miscompares++; $display("FAIL prio_g2: got %b@%0d, required 100@71", gid[2], gcyc[2]); end
        end
    endtask

    task automatic test_fairness();
        int         ng = 0;
        logic [2:0] gid [4];
        logic [2:0] want [4];
        want[0] = 3'b010; want[1] = 3'b100; want[2] = 3'b010; want[3] = 3'b100;
        @(negedge clk);
        req_i = 3'b110; rnw_i = 3'b000; addr_i = 24'h4A4B00; wdata_i = 24'h7A7B00;
        for (int k = 0; k < 4; k++) exp_q.push_back('{want[k], exp_rdata});
        @(posedge clk);
        for (int c = 1; c <= 141; c++) begin
            @(negedge clk);
            if (gnt_o != 3'b000) begin
                if (ng < 4) gid[ng] = gnt_o;
                ng++;
                vectors++;
                if (c != 1 + 35 * (ng - 1)) begin miscompares++; $display("FAIL fair_gnt_cycle: got cycle %0d, required %0d", c, 1 + 35 * (ng - 1)); end
                if (ng == 4) req_i = 3'b000;
            end
        end
        vectors++;
        if (ng != 4) begin miscompares++; $display("FAIL fair_count: got %0d grants, required 4", ng); end
        else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (gid[k] !== want[k]) begin miscompares++; $display("FAIL fair_order %0d: got %b, required %b", k, gid[k], want[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        @(negedge clk);
        req_i = 3'b010; rnw_i[1] = 1'b0; addr_i[15:8] = 8'h10; wdata_i[15:8] = 8'h99;
        @(posedge clk);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1) req_i = 3'b000;
        end
        vectors++;
        if (wr_n !== 1'b0 || cs_n !== 1'b0) begin miscompares++; $display("FAIL midrst_pre: got wr_n=%b cs_n=%b, required 0 0", wr_n, cs_n); end
        rst = 1'b0;
        exp_rdata = 8'h00;
        #1;
        vectors++;
        if (cs_n !== 1'b1 || wr_n !== 1'b1 || ad_oe !== 1'b0) begin miscompares++; $display("FAIL midrst_idle: got cs_n=%b wr_n=%b oe=%b, required 1 1 0", cs_n, wr_n, ad_oe); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_o != 3'b000) ndone++;
        end
        vectors++;
        if (ndone != 0) begin miscompares++; $display("FAIL midrst_no_done: got %0d completions, required 0", ndone); end
        req_i = 3'b100; rnw_i[2] = 1'b1; addr_i[23:16] = 8'h0C; ad_in = 8'h3C;
        exp_rdata = 8'h3C;
        exp_q.push_back('{3'b100, exp_rdata});
        @(posedge clk);
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (gnt_o !== 3'b100) begin miscompares++; $display("FAIL midrst_regrant: got %b, required 100", gnt_o); end
                req_i = 3'b000;
            end
            if (c == 35) begin
                vectors++;
                if (done_o !== 3'b100) begin miscompares++; $display("FAIL midrst_done: got %b, required 100", done_o); end
            end
        end
    endtask

    task automatic test_sweep();
        @(negedge clk);
        s_req = 3'b010; s_rnw = 3'b100; s_addr = 24'h6F5E00; s_wdata = 24'h00A700; s_ad_in = 8'h11;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (s_gnt !== 3'b010) begin miscompares++; $display("FAIL sweep_wgnt: got %b, required 010", s_gnt); end
                s_req = 3'b000;
            end
            vectors++;
            if (s_wr_n !== !(c == 2 || c == 6)) begin miscompares++; $display("FAIL sweep_wr_n c%0d: got %b", c, s_wr_n); end
            if (c == 2 || c == 6) begin
                vectors++;
                if (s_ad_out !== ((c == 2) ? 8'h5E : 8'hA7) || s_a_d !== (c == 6)) begin miscompares++; $display("FAIL sweep_wbus c%0d: got ad_out=%h a_d=%b", c, s_ad_out, s_a_d); end
            end
            if (c >= 8) begin
                vectors++;
                if (s_done !== ((c == 9) ? 3'b010 : 3'b000)) begin miscompares++; $display("FAIL sweep_wdone c%0d: got %b", c, s_done); end
            end
        end
        @(negedge clk);
        s_req = 3'b100; s_ad_in = 8'h81;
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) s_req = 3'b000;
            vectors++;
            if (s_rd_n !== !(c == 6)) begin miscompares++; $display("FAIL sweep_rd_n c%0d: got %b", c, s_rd_n); end
            if (c >= 5 && c <= 7) begin
                vectors++;
                if (s_ad_oe !== 1'b0) begin miscompares++; $display("FAIL sweep_rdir c%0d: got oe=%b, required 0", c, s_ad_oe); end
            end
            if (c == 9) begin
                vectors++;
                if (s_done !== 3'b100 || s_rdata !== 8'h81) begin miscompares++; $display("FAIL sweep_rdone: got done=%b rdata=%h, required 100 81", s_done, s_rdata); end
            end
        end
    endtask

    initial begin
        req_i = '0; rnw_i = '0; addr_i = '0; wdata_i = '0; ad_in = '0;
        s_req = '0; s_rnw = '0; s_addr = '0; s_wdata = '0; s_ad_in = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_priority();
        test_fairness();
        test_sweep();
        test_reset_mid();
        repeat (2) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sched.md
# rtc_bus_sched

Scheduler and bus sequencer for the multiplexed address/data interface of the external RTC. It arbitrates three requesters: init sequence, time-set writer and time readback reader. For each granted transaction it generates the complete address phase, followed by the data phase, on CS/RD/WR/A_D and the tri-state data bus. It sits between the top-level control FSM and the RTC pins, replacing per-requester hardwired signal sequencers.

## Interface
- T_SETUP, 2: cycles CS/A_D/bus valid before the strobe, each phase (≥1)
- T_PULSE, 6: strobe low width, each phase (≥1)
- T_HOLD, 2: cycles after the strobe before CS releases (≥1)
- T_GAP, 10: idle cycles between address and data phase (≥1)
- T_REC, 4: idle cycles after the data phase before the next grant (≥1)
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- req_i  in  3  request per requester: 0 = init, 1 = write, 2 = read
- rnw_i  in  3  per-requester direction: 1 = read, 0 = write
- addr_i  in  24  per-requester RTC register address, 8 bits each, requester n at [8n+7:8n]
- wdata_i  in  24  per-requester write data, same packing
- gnt_o  out  3  one-cycle grant pulse, one-hot
- done_o  out  3  one-cycle completion pulse, one-hot
- rdata_o  out  8  last read data
- ad_in  in  8  RTC bus input from the pad
- ad_out  out  8  RTC bus drive value
- ad_oe  out  1  tri-state enable, 1 = drive
- cs_n, rd_n, wr_n  out  1 each  RTC strobes, active-low
- a_d  out  1  0 = address phase, 1 = data phase

## Operation
- All bus outputs and gnt_o/done_o are registered.
- Idle bus levels: cs_n=1, rd_n=1, wr_n=1, a_d=1, ad_oe=0, ad_out=0.
- Reset values:
  - Bus outputs take their idle levels.
  - gnt_o=0, done_o=0, rdata_o=0.
  - State is IDLE; the round-robin pointer is set so requester 1 wins first.
- Arbitration, evaluated only in IDLE:
  - Requester 0 always wins.
  - If requesters 1 and 2 both request, the one not served last wins.
- On grant:
  - Latch the winner's addr, wdata and rnw.
  - Pulse gnt_o[n].
  - The requester must drop req_i on the cycle after gnt. A req_i still high when the FSM returns to IDLE counts as a new request.
- States and bus levels (each state lasts its parameter in cycles):
  - IDLE: bus idle.
  - ADDR_SETUP (T_SETUP): a_d=0, cs_n=0, ad_oe=1, ad_out=addr.
  - ADDR_STROBE (T_PULSE): as ADDR_SETUP, plus wr_n=0.
  - ADDR_HOLD (T_HOLD): wr_n=1; cs_n, a_d and the bus unchanged.
  - GAP (T_GAP): bus idle.
  - DATA_SETUP (T_SETUP): a_d=1, cs_n=0.
    - Write: ad_oe=1, ad_out=wdata.
    - Read: ad_oe=0.
  - DATA_STROBE (T_PULSE): write drives wr_n=0; read drives rd_n=0.
  - DATA_HOLD (T_HOLD): strobes high; cs_n=0; ad_oe unchanged.
  - RECOVER (T_REC): bus idle, then return to IDLE.
- Read capture: register ad_in into rdata_o on the last DATA_STROBE cycle. rdata_o holds until the next read completes.
- Write transactions leave rdata_o unchanged.
- Asserting rst mid-transaction:
  - Outputs go to idle levels immediately.
  - The transaction is dropped and no done_o is produced.
- rd_n and wr_n are never low simultaneously.
- ad_oe=1 never coincides with rd_n=0.

## Timing
- Requests are sampled at edge 0. Cycle numbering below counts from that edge.
  - Cycle 1: gnt_o pulses in the first ADDR_SETUP cycle.
  - Defaults give ADDR_SETUP 1–2, ADDR_STROBE 3–8, ADDR_HOLD 9–10, GAP 11–20, DATA_SETUP 21–22, DATA_STROBE 23–28, DATA_HOLD 29–30, RECOVER 31–34.
  - Cycle 35: IDLE, with done_o pulsing and rdata_o valid.
- Busy length: 2·(T_SETUP+T_PULSE+T_HOLD)+T_GAP+T_REC = 34 cycles at defaults.
- Back-to-back: a request pending in IDLE at cycle 35 is granted at cycle 36.
- No pipelining; one transaction is in flight at a time.

## Structure
- Package rtc_bus_pkg holds:
  - the state enum;
  - requester index constants (REQ_INI=0, REQ_ESC=1, REQ_LEC=2);
  - the idle-level constants for cs_n, rd_n, wr_n and a_d.
- Sub-module rtc_phase_timer: a down-counter.
  - Loads the duration of the next state on each transition.
  - Flags the last cycle of the current state.
  - Width is $clog2 of the maximum parameter plus 1.
- Arbiter, FSM and output registers live in the top module.

## Test plan
- Single write, requester 1, addr=0x21, wdata=0x45:
  - gnt_o=3'b010 at cycle 1.
  - wr_n low at cycles 3–8 with ad_out=0x21, a_d=0.
  - wr_n low at cycles 23–28 with ad_out=0x45, a_d=1.
  - done_o=3'b010 at cycle 35; rd_n stays 1 throughout.
- Single read, requester 2, addr=0x22, ad_in=0x37 driven during the data phase:
  - rd_n low at cycles 23–28, with ad_oe=0 from cycle 21.
  - rdata_o=0x37 and done_o=3'b100 at cycle 35.
- Priority: req_i=3'b111 from cycle 0:
  - Grant order is 0, then 1, then 2.
  - Grants at cycles 1, 36 and 71.
- Fairness: requesters 1 and 2 held high continuously after their first grant; grants alternate 1, 2, 1, 2.
- Reset mid-operation: rst low at cycle 25 of a write:
  - Same cycle: cs_n=1, wr_n=1, ad_oe=0.
  - No done_o.
  - After release, a new request is granted normally.
- Parameter sweep with all parameters at 1: busy length is 8 cycles; the strobe and bus-direction checks still pass.
